// File: rtl/ym_timer_ctrl.sv
// rtl/ym_timer_ctrl.sv - YM2610 timer register front-end: port decode, busy window, status read (optional YMCTRL_WRBUF_EN write buffer)
module ym_timer_ctrl #(
  parameter int BUSY_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEL,
  input  logic       WR,
  input  logic [1:0] A,
  input  logic [7:0] DIN,
  input  logic       FLAG_A,
  input  logic       FLAG_B,
  output logic [7:0] DOUT,
  output logic [9:0] YMTIMER_TA_LOAD,
  output logic [7:0] YMTIMER_TB_LOAD,
  output logic [5:0] YMTIMER_CONFIG,
  output logic       set_run_A,
  output logic       clr_run_A,
  output logic       set_run_B,
  output logic       clr_run_B,
  output logic       BUSY,
  output logic       WR_DROP
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic        bank_q, bank_d;
  logic [7:0]  dout_q, dout_d;
  logic [9:0]  ta_q, ta_d;
  logic [7:0]  tb_q, tb_d;
  logic [3:0]  cfg_q, cfg_d;
  logic [1:0]  cfg_clr_q, cfg_clr_d;
  logic [3:0]  run_q, run_d;      // {clr_run_B, set_run_B, clr_run_A, set_run_A}
  logic        drop_q, drop_d;

  // Selected register write for this cycle (from the bus or from the buffer)
  logic        apply_en;
  logic [7:0]  apply_addr;
  logic        apply_bankb;
  logic [7:0]  apply_data;

  logic        wr_data;
  logic        wr_addr;
  logic        rd;
  logic        in_bankb;

`ifdef YMCTRL_WRBUF_EN
  logic        buf_full_q, buf_full_d;
  logic [7:0]  buf_addr_q, buf_addr_d;
  logic        buf_bankb_q, buf_bankb_d;
  logic [7:0]  buf_data_q, buf_data_d;
`endif

  assign wr_data  = SEL & WR & A[0];
  assign wr_addr  = SEL & WR & ~A[0];
  assign rd       = SEL & ~WR;
  // Effects land only on bank A through the bank-A data port
  assign in_bankb = bank_q | A[1];

  // Next-state: bus decode, busy window sequencing and register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    bank_d      = bank_q;
    dout_d      = dout_q;
    ta_d        = ta_q;
    tb_d        = tb_q;
    cfg_d       = cfg_q;
    cfg_clr_d   = 2'b00;
    run_d       = 4'b0000;
    drop_d      = 1'b0;
    apply_en    = 1'b0;
    apply_addr  = addr_q;
    apply_bankb = in_bankb;
    apply_data  = DIN;
`ifdef YMCTRL_WRBUF_EN
    buf_full_d  = buf_full_q;
    buf_addr_d  = buf_addr_q;
    buf_bankb_d = buf_bankb_q;
    buf_data_d  = buf_data_q;
`endif

    if (wr_addr) begin
      addr_d = DIN;
      bank_d = A[1];
    end

    if (rd) begin
      dout_d = A[0] ? 8'h00 : {(state_q == S_BUSY), 5'b00000, FLAG_B, FLAG_A};
    end

    case (state_q)
      S_IDLE: begin
        if (wr_data) begin
          apply_en = 1'b1;
          state_d  = S_BUSY;
          cnt_d    = 8'(BUSY_CYCLES);
        end
      end
      S_BUSY: begin
`ifdef YMCTRL_WRBUF_EN
        drop_d = wr_data & buf_full_q;
        if (cnt_q == 8'd1) begin
          // Last busy cycle: a pending write chains straight into a new window
          if (buf_full_q) begin
            apply_en    = 1'b1;
            apply_addr  = buf_addr_q;
            apply_bankb = buf_bankb_q;
            apply_data  = buf_data_q;
            buf_full_d  = 1'b0;
            cnt_d       = 8'(BUSY_CYCLES);
          end else if (wr_data) begin
            apply_en = 1'b1;
            cnt_d    = 8'(BUSY_CYCLES);
          end else begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (wr_data && !buf_full_q) begin
            buf_full_d  = 1'b1;
            buf_addr_d  = addr_q;
            buf_bankb_d = in_bankb;
            buf_data_d  = DIN;
          end
        end
`else
        drop_d = wr_data;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (apply_en && !apply_bankb) begin
      case (apply_addr)
        8'h24: ta_d[9:2] = apply_data;
        8'h25: ta_d[1:0] = apply_data[1:0];
        8'h26: tb_d      = apply_data;
        8'h27: begin
          run_d[0]  = apply_data[0] & ~cfg_q[0];
          run_d[1]  = ~apply_data[0] & cfg_q[0];
          run_d[2]  = apply_data[1] & ~cfg_q[1];
          run_d[3]  = ~apply_data[1] & cfg_q[1];
          cfg_d     = apply_data[3:0];
          cfg_clr_d = apply_data[5:4];
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 8'h00;
      bank_q    <= 1'b0;
      dout_q    <= 8'h00;
      ta_q      <= 10'd0;
      tb_q      <= 8'd0;
      cfg_q     <= 4'd0;
      cfg_clr_q <= 2'd0;
      run_q     <= 4'd0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      dout_q    <= dout_d;
      ta_q      <= ta_d;
      tb_q      <= tb_d;
      cfg_q     <= cfg_d;
      cfg_clr_q <= cfg_clr_d;
      run_q     <= run_d;
      drop_q    <= drop_d;
    end
  end

`ifdef YMCTRL_WRBUF_EN
  // One-entry write buffer holding a data write that arrived during the window
  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_full_q  <= 1'b0;
      buf_addr_q  <= 8'h00;
      buf_bankb_q <= 1'b0;
      buf_data_q  <= 8'h00;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_addr_q  <= buf_addr_d;
      buf_bankb_q <= buf_bankb_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  assign DOUT            = dout_q;
  assign YMTIMER_TA_LOAD = ta_q;
  assign YMTIMER_TB_LOAD = tb_q;
  assign YMTIMER_CONFIG  = {cfg_clr_q, cfg_q};
  assign set_run_A       = run_q[0];
  assign clr_run_A       = run_q[1];
  assign set_run_B       = run_q[2];
  assign clr_run_B       = run_q[3];
  assign BUSY            = (state_q == S_BUSY);
  assign WR_DROP         = drop_q;

endmodule
